// File: rtl/delay_line_ctrl.sv
// Measurement sequencer for an external register delay chain: flush, launch a marker, time its arrival.
// Optional min/max latency statistics are built only when DELAY_LINE_CTRL_STATS_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start, results from last run held
// S_FLUSH   | driving idle level until chain_dout idle for FLUSH_LEN cycles
// S_LAUNCH  | one cycle; marker registered onto chain_din at its end
// S_MEASURE | counting cycles until the marker reaches chain_dout
// S_DONE    | latency posted, waiting for start
// S_ERR     | stuck/timeout error posted, waiting for start
module delay_line_ctrl #(
   parameter int   CNT_W     = 8,
   parameter int   TIMEOUT   = 255,
   parameter int   FLUSH_LEN = 4,
   parameter logic IDLE_LVL  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             chain_din,
   input  logic             chain_dout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] lat,
   output logic             err_stuck,
   output logic             err_tmo,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat,
   input  logic             clr_stats
);

   localparam int RUN_W = $clog2(FLUSH_LEN + 1);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [RUN_W-1:0] RUN_LEN = RUN_W'(FLUSH_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_LAUNCH,
      S_MEASURE,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [RUN_W-1:0] idle_run, idle_run_nxt, run_inc;
   logic [CNT_W-1:0] lat_nxt;
   logic             chain_din_nxt, busy_nxt, done_nxt;
   logic             err_stuck_nxt, err_tmo_nxt;
   logic             meas_ok;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idle_run_nxt  = idle_run;
      lat_nxt       = lat;
      err_stuck_nxt = err_stuck;
      err_tmo_nxt   = err_tmo;
      done_nxt      = 1'b0;
      meas_ok       = 1'b0;
      chain_din_nxt = IDLE_LVL;
      // saturating counters: never wrap past TIMEOUT / FLUSH_LEN
      cnt_inc       = (cnt == TMO) ? cnt : cnt + 1'b1;
      run_inc       = '0;
      if (chain_dout == IDLE_LVL)
         run_inc = (idle_run == RUN_LEN) ? idle_run : idle_run + 1'b1;

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt     = S_FLUSH;
               err_stuck_nxt = 1'b0;
               err_tmo_nxt   = 1'b0;
               cnt_nxt       = '0;
               idle_run_nxt  = '0;
            end
         end
         S_FLUSH: begin
            cnt_nxt      = cnt_inc;
            idle_run_nxt = run_inc;
            if (run_inc == RUN_LEN) begin
               state_nxt = S_LAUNCH;
            end else if (cnt_inc == TMO) begin
               state_nxt     = S_ERR;
               err_stuck_nxt = 1'b1;
               done_nxt      = 1'b1;
            end
         end
         S_LAUNCH: begin
            state_nxt     = S_MEASURE;
            chain_din_nxt = ~IDLE_LVL;
            cnt_nxt       = '0;
         end
         S_MEASURE: begin
            // marker check uses this cycle's cnt, so a wire chain measures 0
            if (chain_dout != IDLE_LVL) begin
               state_nxt = S_DONE;
               lat_nxt   = cnt;
               done_nxt  = 1'b1;
               meas_ok   = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == TMO) begin
                  state_nxt   = S_ERR;
                  err_tmo_nxt = 1'b1;
                  done_nxt    = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (abort) begin
         state_nxt     = S_IDLE;
         cnt_nxt       = cnt;
         idle_run_nxt  = idle_run;
         lat_nxt       = lat;
         err_stuck_nxt = err_stuck;
         err_tmo_nxt   = err_tmo;
         done_nxt      = 1'b0;
         meas_ok       = 1'b0;
         chain_din_nxt = IDLE_LVL;
      end

      busy_nxt = (state_nxt == S_FLUSH) || (state_nxt == S_LAUNCH) ||
                 (state_nxt == S_MEASURE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         idle_run  <= '0;
         chain_din <= IDLE_LVL;
         busy      <= 1'b0;
         done      <= 1'b0;
         lat       <= '0;
         err_stuck <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idle_run  <= idle_run_nxt;
         chain_din <= chain_din_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         lat       <= lat_nxt;
         err_stuck <= err_stuck_nxt;
         err_tmo   <= err_tmo_nxt;
      end
   end

`ifdef DELAY_LINE_CTRL_STATS_EN
   // clear takes precedence over a same-cycle result update
   always_ff @(posedge clk) begin
      if (!rst_n || clr_stats) begin
         min_lat <= '1;
         max_lat <= '0;
      end else if (meas_ok) begin
         if (cnt < min_lat) min_lat <= cnt;
         if (cnt > max_lat) max_lat <= cnt;
      end
   end
`else
   logic unused_stats;
   assign unused_stats = clr_stats ^ meas_ok;
   assign min_lat      = '1;
   assign max_lat      = '0;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: behavioural delay chain plus a latency/timing reference model.
// Honours DELAY_LINE_CTRL_STATS_EN the same way as the design.
module tb_delay_line_ctrl;

   localparam int CNT_W     = 8;
   localparam int TIMEOUT   = 255;
   localparam int FLUSH_LEN = 4;
   localparam int M_CHAIN   = 0;
   localparam int M_STUCK0  = 1;
   localparam int M_STUCK1  = 2;

   logic             clk, rst_n, start, abort, clr_stats;
   logic             chain_din, chain_dout, busy, done, err_stuck, err_tmo;
   logic [CNT_W-1:0] lat, min_lat, max_lat;

   int total = 0, bad = 0;
   int done_cnt = 0, marker_cnt = 0;
   int mode, n_flops;
   int exp_lat = 0, exp_min = 255, exp_max = 0;
   logic [255:0] sr;

   delay_line_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FLUSH_LEN(FLUSH_LEN), .IDLE_LVL(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .chain_din(chain_din), .chain_dout(chain_dout), .busy(busy), .done(done),
      .lat(lat), .err_stuck(err_stuck), .err_tmo(err_tmo),
      .min_lat(min_lat), .max_lat(max_lat), .clr_stats(clr_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external chain: N flops reloading idle level on reset
   always @(posedge clk) begin
      if (!rst_n) sr <= '1;
      else        sr <= {sr[254:0], chain_din};
   end

   always_comb begin
      chain_dout = chain_din;
      if (mode == M_STUCK0)      chain_dout = 1'b0;
      else if (mode == M_STUCK1) chain_dout = 1'b1;
      else if (n_flops > 0)      chain_dout = sr[n_flops-1];
   end

   task tick();
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (chain_din === 1'b0) marker_cnt++;
   endtask

   task settle();
      for (int i = 0; i < 300 && sr !== '1; i++) tick();
      tick();
   endtask

   task start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < budget && !ok) begin
         tick();
         cyc++;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic check_stats(input string tag);
      total++;
      if (min_lat !== CNT_W'(exp_min) || max_lat !== CNT_W'(exp_max)) begin
         bad++;
         $display("FAIL %s: min/max got %0d/%0d want %0d/%0d", tag, min_lat, max_lat, exp_min, exp_max);
      end
   endtask

   // One clean measurement; done expected FLUSH_LEN + LAUNCH + (n+1) measure cycles after start.
   task automatic run_measure(input int n);
      int cyc;
      bit ok;
      settle();
      mode = M_CHAIN; n_flops = n; done_cnt = 0; marker_cnt = 0;
      start_pulse();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_start n=%0d: got %0b want 1", n, busy); end
      wait_done(TIMEOUT + FLUSH_LEN + 20, cyc, ok);
      total++;
      if (!ok || cyc != n + FLUSH_LEN + 2) begin
         bad++; $display("FAIL done_time n=%0d: got %0d (seen=%0b) want %0d", n, cyc, ok, n + FLUSH_LEN + 2);
      end
      total++;
      if (lat !== CNT_W'(n)) begin bad++; $display("FAIL lat n=%0d: got %0d want %0d", n, lat, n); end
      total++;
      if (err_stuck !== 1'b0 || err_tmo !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL flags n=%0d: got stuck=%0b tmo=%0b busy=%0b want 0/0/0", n, err_stuck, err_tmo, busy);
      end
      tick(); tick();
      total++;
      if (done_cnt != 1 || marker_cnt != 1) begin
         bad++; $display("FAIL pulses n=%0d: got done=%0d marker=%0d want 1/1", n, done_cnt, marker_cnt);
      end
      exp_lat = n;
`ifdef DELAY_LINE_CTRL_STATS_EN
      if (n < exp_min) exp_min = n;
      if (n > exp_max) exp_max = n;
`endif
      check_stats("stats_run");
   endtask

   task test_reset();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || lat !== '0 || err_stuck !== 1'b0 ||
          err_tmo !== 1'b0 || chain_din !== 1'b1) begin
         bad++;
         $display("FAIL reset: got busy=%0b done=%0b lat=%0d stuck=%0b tmo=%0b din=%0b want 0/0/0/0/0/1",
                  busy, done, lat, err_stuck, err_tmo, chain_din);
      end
      exp_lat = 0; exp_min = 255; exp_max = 0;
      check_stats("stats_reset");
   endtask

   task test_measure();
      run_measure(100);
      run_measure(0);
      for (int i = 0; i < 5; i++) run_measure(int'($urandom_range(1, 200)));
      run_measure(TIMEOUT - 1);
   endtask

   task automatic test_stuck(input int m);
      int cyc, want;
      bit ok;
      settle();
      mode = m; done_cnt = 0; marker_cnt = 0;
      start_pulse();
      want = (m == M_STUCK0) ? TIMEOUT : FLUSH_LEN + 1 + TIMEOUT;
      wait_done(400, cyc, ok);
      total++;
      if (!ok || cyc != want) begin bad++; $display("FAIL err_time mode=%0d: got %0d (seen=%0b) want %0d", m, cyc, ok, want); end
      total++;
      if (err_stuck !== (m == M_STUCK0) || err_tmo !== (m == M_STUCK1) || busy !== 1'b0) begin
         bad++; $display("FAIL err_flags mode=%0d: got stuck=%0b tmo=%0b busy=%0b", m, err_stuck, err_tmo, busy);
      end
      total++;
      if (lat !== CNT_W'(exp_lat)) begin bad++; $display("FAIL err_lat mode=%0d: got %0d want %0d", m, lat, exp_lat); end
      tick(); tick();
      total++;
      if (done_cnt != 1 || marker_cnt != (m == M_STUCK1 ? 1 : 0)) begin
         bad++; $display("FAIL err_pulses mode=%0d: got done=%0d marker=%0d", m, done_cnt, marker_cnt);
      end
      check_stats("stats_err");
      mode = M_CHAIN;
   endtask

   task test_start_busy();
      int cyc;
      bit ok;
      settle();
      mode = M_CHAIN; n_flops = 40; done_cnt = 0;
      start_pulse();
      cyc = 0; ok = 1'b0;
      while (cyc < 200 && !ok) begin
         tick();
         cyc++;
         start = (cyc == 2 || cyc == 15);
         if (done) ok = 1'b1;
      end
      start = 1'b0;
      total++;
      if (!ok || cyc != 40 + FLUSH_LEN + 2 || lat !== CNT_W'(40)) begin
         bad++; $display("FAIL start_busy: got cyc=%0d lat=%0d want %0d/40", cyc, lat, 40 + FLUSH_LEN + 2);
      end
      exp_lat = 40;
`ifdef DELAY_LINE_CTRL_STATS_EN
      if (40 < exp_min) exp_min = 40;
      if (40 > exp_max) exp_max = 40;
`endif
   endtask

   task test_abort();
      int k;
      settle();
      mode = M_CHAIN; n_flops = 100; done_cnt = 0;
      start_pulse();
      k = 0;
      while (k < 20 && chain_din !== 1'b0) begin tick(); k++; end
      total++;
      if (chain_din !== 1'b0) begin bad++; $display("FAIL abort_launch: got din=%0b want 0", chain_din); end
      repeat (50) tick();
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      total++;
      if (busy !== 1'b0 || chain_din !== 1'b1 || lat !== CNT_W'(exp_lat) || err_stuck !== 1'b0 || err_tmo !== 1'b0) begin
         bad++; $display("FAIL abort_state: got busy=%0b din=%0b lat=%0d stuck=%0b tmo=%0b want 0/1/%0d/0/0",
                         busy, chain_din, lat, err_stuck, err_tmo, exp_lat);
      end
      repeat (120) tick();
      total++;
      if (done_cnt != 0 || busy !== 1'b0) begin bad++; $display("FAIL abort_quiet: got done=%0d busy=%0b want 0/0", done_cnt, busy); end
      check_stats("stats_abort");
      run_measure(100);
      // start together with abort from a result-holding state: abort wins
      done_cnt = 0;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || done_cnt != 0 || lat !== CNT_W'(exp_lat)) begin
         bad++; $display("FAIL start_abort: got busy=%0b done=%0d lat=%0d want 0/0/%0d", busy, done_cnt, lat, exp_lat);
      end
   endtask

   task test_stats();
      int cyc;
      bit ok;
      clr_stats = 1'b1; tick(); clr_stats = 1'b0;
      exp_min = 255; exp_max = 0;
      check_stats("stats_clr0");
      run_measure(10);
      run_measure(30);
      run_measure(20);
`ifdef DELAY_LINE_CTRL_STATS_EN
      total++;
      if (min_lat !== 8'd10 || max_lat !== 8'd30) begin
         bad++; $display("FAIL stats_10_30_20: got %0d/%0d want 10/30", min_lat, max_lat);
      end
`endif
      test_stuck(M_STUCK0);
      // clear held across a DONE update must win
      settle();
      n_flops = 15; clr_stats = 1'b1;
      start_pulse();
      wait_done(100, cyc, ok);
      tick();
      clr_stats = 1'b0;
      exp_min = 255; exp_max = 0;
      total++;
      if (!ok || lat !== 8'd15) begin bad++; $display("FAIL clr_run: got lat=%0d seen=%0b want 15", lat, ok); end
      exp_lat = 15;
      check_stats("stats_clr_done");
   endtask

   task test_reset_mid();
      settle();
      n_flops = 100;
      start_pulse();
      tick();
      rst_n = 1'b0;
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
      run_measure(7);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; clr_stats = 1'b0;
      mode = M_CHAIN; n_flops = 0;
      tick(); tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_measure();
      test_stuck(M_STUCK0);
      test_stuck(M_STUCK1);
      test_start_busy();
      test_abort();
      test_stats();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
